// File: rtl/exec_pkg.sv
// exec_pkg
// Shared definitions for the execute stage: operation codes, carry-select
// codes, the bit positions inside the condition-code register, and a small
// helper that resolves the next carry flag.
package exec_pkg;

    // Operation codes presented on ALUmode
    typedef enum logic [2:0] {
        ALU_ADD  = 3'b000,
        ALU_SUB  = 3'b001,
        ALU_AND  = 3'b010,
        ALU_OR   = 3'b011,
        ALU_NOT  = 3'b100,
        ALU_PASS = 3'b101,
        ALU_MUL  = 3'b110,
        ALU_NOP  = 3'b111
    } alu_mode_e;

    // Carry control presented on carrySelect, applied when an operation retires
    typedef enum logic [1:0] {
        CSEL_KEEP  = 2'b00,
        CSEL_SET   = 2'b01,
        CSEL_OP    = 2'b10,
        CSEL_CLEAR = 2'b11
    } carry_sel_e;

    // Condition-code register layout {C,N,Z}
    localparam int C_BIT = 2;
    localparam int N_BIT = 1;
    localparam int Z_BIT = 0;

    // Operations that produce no carry of their own leave C alone even when
    // the carry is requested from the operation.
    function automatic logic carry_next(input carry_sel_e sel,
                                        input logic       c_old,
                                        input logic       has_c,
                                        input logic       c_op);
        logic c;
        c = c_old;
        case (sel)
            CSEL_KEEP:  c = c_old;
            CSEL_SET:   c = 1'b1;
            CSEL_OP:    c = has_c ? c_op : c_old;
            CSEL_CLEAR: c = 1'b0;
            default:    c = c_old;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/seq_multiplier.sv
// seq_multiplier
// Iterative unsigned shift-add multiplier. A start pulse captures both
// operands; the unit then consumes BPC multiplier bits per cycle for
// MUL_CYCLES cycles. done is raised combinationally during the final
// iteration and product already includes that iteration, so the caller can
// register the product on the same edge that ends the multiply.
// Ports:
//   clk, reset   clock and asynchronous active-low reset
//   start        load operands and begin (ignored while abort is high)
//   abort        drop any multiply in progress
//   op_a, op_b   multiplicand and multiplier, WIDTH bits
//   done         final iteration in progress this cycle
//   product      full 2*WIDTH-bit product, valid while done is high
module seq_multiplier #(
    parameter int WIDTH      = 16,
    parameter int MUL_CYCLES = WIDTH
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic [WIDTH-1:0]   op_a,
    input  logic [WIDTH-1:0]   op_b,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    // Multiplier bits retired per cycle, rounded up so every bit is covered
    localparam int BPC   = (WIDTH + MUL_CYCLES - 1) / MUL_CYCLES;
    localparam int CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MUL_CYCLES - 1);

    logic                 active_q, active_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [2*WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [2*WIDTH-1:0]   partial;
    logic [2*WIDTH-1:0]   acc_next;

    // One iteration: add the multiplicand shifted by each set bit of the
    // current multiplier chunk.
    always_comb begin
        partial = '0;
        for (int b = 0; b < BPC; b++) begin
            if (mplier_q[b]) begin
                partial = partial + (mcand_q << b);
            end
        end
        acc_next = acc_q + partial;
    end

    assign done    = active_q && (count_q == LAST_CNT);
    assign product = acc_next;

    // Abort wins over start; the running state advances one chunk per cycle
    always_comb begin
        active_d = active_q;
        count_d  = count_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        if (abort) begin
            active_d = 1'b0;
        end else if (start) begin
            active_d = 1'b1;
            count_d  = '0;
            acc_d    = '0;
            mcand_d  = {{WIDTH{1'b0}}, op_a};
            mplier_d = op_b;
        end else if (active_q) begin
            if (done) begin
                active_d = 1'b0;
            end else begin
                count_d = count_q + 1'b1;
            end
            acc_d    = acc_next;
            mcand_d  = mcand_q << BPC;
            mplier_d = mplier_q >> BPC;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            active_q <= 1'b0;
            count_q  <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
        end else begin
            active_q <= active_d;
            count_q  <= count_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
        end
    end

endmodule

// File: rtl/exec_unit.sv
// exec_unit
// Execute stage of the pipelined core. Single-cycle operations retire on
// the edge that accepts them; MUL hands its operands to seq_multiplier and
// holds the unit busy until the product retires. The unit owns the
// condition-code register {C,N,Z}.
// Ports:
//   clk, reset                clock and asynchronous active-low reset
//   in_valid / in_ready       operation handshake; in_ready depends on state only
//   Op1, Op2, ALUmode         operands and operation code
//   carrySelect               carry control applied at retire
//   flush                     synchronous abort, highest priority
//   result_r                  registered result
//   out_valid                 one-cycle pulse when result_r/CCR update
//   conditionCodeRegister_r   {C,N,Z}
//   busy                      MUL in progress
module exec_unit
    import exec_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int MUL_CYCLES = WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] Op1,
    input  logic [WIDTH-1:0] Op2,
    input  logic [2:0]       ALUmode,
    input  logic [1:0]       carrySelect,
    input  logic             flush,
    output logic [WIDTH-1:0] result_r,
    output logic             out_valid,
    output logic [2:0]       conditionCodeRegister_r,
    output logic             busy
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    logic [0:0]         state_q, state_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [2:0]         ccr_q, ccr_d;
    logic               out_valid_q, out_valid_d;
    carry_sel_e         sel_q, sel_d;

    alu_mode_e          mode;
    carry_sel_e         csel;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_c;
    logic               alu_has_c;
    logic               alu_upd_zn;

    logic               mul_start;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_product;

    assign mode = alu_mode_e'(ALUmode);
    assign csel = carry_sel_e'(carrySelect);

    // Builds the next {C,N,Z}; Z and N follow the result only for
    // operations that define them.
    function automatic logic [2:0] ccr_next(input logic [2:0]       ccr_old,
                                            input logic [WIDTH-1:0] res,
                                            input logic             upd_zn,
                                            input logic             has_c,
                                            input logic             c_op,
                                            input carry_sel_e       sel);
        logic [2:0] ccr;
        ccr        = ccr_old;
        ccr[C_BIT] = carry_next(sel, ccr_old[C_BIT], has_c, c_op);
        if (upd_zn) begin
            ccr[N_BIT] = res[WIDTH-1];
            ccr[Z_BIT] = (res == '0);
        end
        return ccr;
    endfunction

    // Combinational ALU for the single-cycle operations. The extra top bit
    // of the SUB difference is set exactly when Op1 < Op2, i.e. the borrow.
    always_comb begin
        alu_res    = '0;
        alu_c      = 1'b0;
        alu_has_c  = 1'b0;
        alu_upd_zn = 1'b0;
        case (mode)
            ALU_ADD: begin
                {alu_c, alu_res} = {1'b0, Op1} + {1'b0, Op2};
                alu_has_c  = 1'b1;
                alu_upd_zn = 1'b1;
            end
            ALU_SUB: begin
                {alu_c, alu_res} = {1'b0, Op1} - {1'b0, Op2};
                alu_has_c  = 1'b1;
                alu_upd_zn = 1'b1;
            end
            ALU_AND: begin
                alu_res    = Op1 & Op2;
                alu_upd_zn = 1'b1;
            end
            ALU_OR: begin
                alu_res    = Op1 | Op2;
                alu_upd_zn = 1'b1;
            end
            ALU_NOT: begin
                alu_res    = ~Op1;
                alu_upd_zn = 1'b1;
            end
            ALU_PASS: alu_res = Op2;
            ALU_NOP:  alu_res = result_q;
            default:  alu_res = result_q;
        endcase
    end

    // Control: flush dominates everything; while busy only the multiplier
    // retire can update the outputs; while idle an offered operation is
    // either retired immediately or launched into the multiplier, whose
    // carry control is held until it retires.
    always_comb begin
        state_d     = state_q;
        result_d    = result_q;
        ccr_d       = ccr_q;
        out_valid_d = 1'b0;
        sel_d       = sel_q;
        mul_start   = 1'b0;
        if (flush) begin
            state_d = ST_IDLE;
        end else if (state_q == ST_BUSY) begin
            if (mul_done) begin
                result_d    = mul_product[WIDTH-1:0];
                ccr_d       = ccr_next(ccr_q, mul_product[WIDTH-1:0], 1'b1, 1'b1,
                                       |mul_product[2*WIDTH-1:WIDTH], sel_q);
                out_valid_d = 1'b1;
                state_d     = ST_IDLE;
            end
        end else if (in_valid) begin
            if (mode == ALU_MUL) begin
                mul_start = 1'b1;
                sel_d     = csel;
                state_d   = ST_BUSY;
            end else begin
                result_d    = alu_res;
                ccr_d       = ccr_next(ccr_q, alu_res, alu_upd_zn, alu_has_c, alu_c, csel);
                out_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            result_q    <= '0;
            ccr_q       <= 3'b000;
            out_valid_q <= 1'b0;
            sel_q       <= CSEL_KEEP;
        end else begin
            state_q     <= state_d;
            result_q    <= result_d;
            ccr_q       <= ccr_d;
            out_valid_q <= out_valid_d;
            sel_q       <= sel_d;
        end
    end

    seq_multiplier #(
        .WIDTH      (WIDTH),
        .MUL_CYCLES (MUL_CYCLES)
    ) u_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (mul_start),
        .abort   (flush),
        .op_a    (Op1),
        .op_b    (Op2),
        .done    (mul_done),
        .product (mul_product)
    );

    assign in_ready                = (state_q == ST_IDLE);
    assign busy                    = (state_q == ST_BUSY);
    assign result_r                = result_q;
    assign out_valid               = out_valid_q;
    assign conditionCodeRegister_r = ccr_q;

endmodule

// File: tb/tb_exec_unit.sv
// tb_exec_unit
// Self-checking bench for exec_unit (WIDTH=16, MUL_CYCLES=16). Expected
// results and flags come from a plain-arithmetic model of the operation set.
module tb_exec_unit;

    localparam int WIDTH      = 16;
    localparam int MUL_CYCLES = 16;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [WIDTH-1:0]  Op1 = '0;
    logic [WIDTH-1:0]  Op2 = '0;
    logic [2:0]        ALUmode = 3'b111;
    logic [1:0]        carrySelect = 2'b00;
    logic              flush = 1'b0;
    logic [WIDTH-1:0]  result_r;
    logic              out_valid;
    logic [2:0]        conditionCodeRegister_r;
    logic              busy;

    int                checks = 0;
    int                errors = 0;

    logic [15:0]       mResult = '0;
    logic [2:0]        mCcr = '0;

    int                n;
    int                lowCount;
    logic              sawValid;

    exec_unit #(
        .WIDTH      (WIDTH),
        .MUL_CYCLES (MUL_CYCLES)
    ) dut (
        .clk                     (clk),
        .reset                   (reset),
        .in_valid                (in_valid),
        .in_ready                (in_ready),
        .Op1                     (Op1),
        .Op2                     (Op2),
        .ALUmode                 (ALUmode),
        .carrySelect             (carrySelect),
        .flush                   (flush),
        .result_r                (result_r),
        .out_valid               (out_valid),
        .conditionCodeRegister_r (conditionCodeRegister_r),
        .busy                    (busy)
    );

    always #5 clk = ~clk;

    // Guard against a hung handshake
    initial begin
        #1ms;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Architectural effect of one retired operation, straight from the
    // operation table: result, flags, then carry control.
    task automatic modelOp(input logic [2:0] op, input logic [15:0] a,
                           input logic [15:0] b, input logic [1:0] sel);
        logic [31:0] wide;
        logic [15:0] res;
        bit          hasC;
        bit          updZn;
        bit          cOp;
        logic        c;
        res   = mResult;
        hasC  = 0;
        updZn = 1;
        cOp   = 0;
        case (op)
            3'd0: begin
                wide = {16'd0, a} + {16'd0, b};
                res  = wide[15:0];
                hasC = 1;
                cOp  = (wide > 32'h0000_FFFF);
            end
            3'd1: begin
                res  = a - b;
                hasC = 1;
                cOp  = (a < b);
            end
            3'd2: res = a & b;
            3'd3: res = a | b;
            3'd4: res = ~a;
            3'd5: begin
                res   = b;
                updZn = 0;
            end
            3'd6: begin
                wide = {16'd0, a} * {16'd0, b};
                res  = wide[15:0];
                hasC = 1;
                cOp  = ((wide >> 16) != 0);
            end
            default: updZn = 0;
        endcase
        c = mCcr[2];
        case (sel)
            2'd1: c = 1'b1;
            2'd2: if (hasC) c = cOp;
            2'd3: c = 1'b0;
            default: c = mCcr[2];
        endcase
        if (updZn) begin
            mCcr[1] = res[15];
            mCcr[0] = (res == 16'd0);
        end
        mCcr[2] = c;
        if (op != 3'd7) mResult = res;
    endtask

    // One complete transaction: wait for ready, offer, scramble the inputs
    // after acceptance, then check latency, result, flags and pulse width.
    task automatic applyStimulus(input string tag, input logic [2:0] op,
                                 input logic [15:0] a, input logic [15:0] b,
                                 input logic [1:0] sel);
        int k;
        int expLat;
        @(negedge clk);
        k = 0;
        while (!in_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        checkOutput({tag, "_ready"}, 32'(in_ready), 32'd1);
        Op1 = a;
        Op2 = b;
        ALUmode = op;
        carrySelect = sel;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        Op1 = 16'($urandom);
        Op2 = 16'($urandom);
        ALUmode = 3'($urandom);
        carrySelect = 2'($urandom);
        modelOp(op, a, b, sel);
        expLat = (op == 3'b110) ? MUL_CYCLES : 0;
        k = 0;
        while (!out_valid && k < MUL_CYCLES + 4) begin
            @(posedge clk);
            #1;
            k++;
        end
        checkOutput({tag, "_lat"}, 32'(k), 32'(expLat));
        checkOutput({tag, "_res"}, 32'(result_r), 32'(mResult));
        checkOutput({tag, "_ccr"}, 32'(conditionCodeRegister_r), 32'(mCcr));
        @(posedge clk);
        #1;
        checkOutput({tag, "_pulse"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        // Reset state
        #12;
        checkOutput("rst_res", 32'(result_r), 32'd0);
        checkOutput("rst_ccr", 32'(conditionCodeRegister_r), 32'd0);
        checkOutput("rst_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        checkOutput("rst_ready", 32'(in_ready), 32'd1);

        // Additions and subtraction with carry from the operation
        applyStimulus("add1", 3'd0, 16'd15, 16'd24, 2'b10);
        checkOutput("add1_const", {13'd0, conditionCodeRegister_r, result_r}, {13'd0, 3'b000, 16'd39});
        applyStimulus("add2", 3'd0, 16'hFFFF, 16'h0001, 2'b10);
        checkOutput("add2_const", {13'd0, conditionCodeRegister_r, result_r}, {13'd0, 3'b101, 16'h0000});
        applyStimulus("sub1", 3'd1, 16'd2, 16'd5, 2'b10);
        checkOutput("sub1_const", {13'd0, conditionCodeRegister_r, result_r}, {13'd0, 3'b110, 16'hFFFD});

        // MUL with an ADD held on the inputs throughout the busy window
        @(negedge clk);
        Op1 = 16'd300; Op2 = 16'd300; ALUmode = 3'd6; carrySelect = 2'b10;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        modelOp(3'd6, 16'd300, 16'd300, 2'b10);
        Op1 = 16'd5; Op2 = 16'd6; ALUmode = 3'd0; carrySelect = 2'b10;
        n = 0;
        lowCount = 0;
        while (!out_valid && n < MUL_CYCLES + 4) begin
            if (!in_ready && busy) lowCount++;
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("mul_lat", 32'(n), 32'(MUL_CYCLES));
        checkOutput("mul_low", 32'(lowCount), 32'(MUL_CYCLES));
        checkOutput("mul_res", 32'(result_r), 32'h5F90);
        checkOutput("mul_ccr", 32'(conditionCodeRegister_r), 32'b100);
        checkOutput("mul_model", 32'(result_r), 32'(mResult));
        checkOutput("mul_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        modelOp(3'd0, 16'd5, 16'd6, 2'b10);
        in_valid = 1'b0;
        checkOutput("mulnext_valid", 32'(out_valid), 32'd1);
        checkOutput("mulnext_res", 32'(result_r), 32'd11);
        checkOutput("mulnext_ccr", 32'(conditionCodeRegister_r), 32'(mCcr));

        // Flush in the eighth cycle of a MUL
        @(negedge clk);
        Op1 = 16'd7; Op2 = 16'd9; ALUmode = 3'd6; carrySelect = 2'b01;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        sawValid = 1'b0;
        repeat (7) begin
            @(posedge clk);
            #1;
            if (out_valid) sawValid = 1'b1;
        end
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        if (out_valid) sawValid = 1'b1;
        checkOutput("flush_ready", 32'(in_ready), 32'd1);
        checkOutput("flush_busy", 32'(busy), 32'd0);
        repeat (MUL_CYCLES) begin
            @(posedge clk);
            #1;
            if (out_valid) sawValid = 1'b1;
        end
        checkOutput("flush_novalid", 32'(sawValid), 32'd0);
        checkOutput("flush_res", 32'(result_r), 32'(mResult));
        checkOutput("flush_ccr", 32'(conditionCodeRegister_r), 32'(mCcr));

        // Flush in the cycle the MUL would retire
        @(negedge clk);
        Op1 = 16'd100; Op2 = 16'd3; ALUmode = 3'd6; carrySelect = 2'b11;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        sawValid = 1'b0;
        repeat (MUL_CYCLES - 1) begin
            @(posedge clk);
            #1;
            if (out_valid) sawValid = 1'b1;
        end
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        if (out_valid) sawValid = 1'b1;
        @(posedge clk);
        #1;
        if (out_valid) sawValid = 1'b1;
        checkOutput("flushret_novalid", 32'(sawValid), 32'd0);
        checkOutput("flushret_ready", 32'(in_ready), 32'd1);
        checkOutput("flushret_res", 32'(result_r), 32'(mResult));
        checkOutput("flushret_ccr", 32'(conditionCodeRegister_r), 32'(mCcr));

        // Flush while idle blocks an offered operation
        @(negedge clk);
        Op1 = 16'd1; Op2 = 16'd1; ALUmode = 3'd0; carrySelect = 2'b01;
        in_valid = 1'b1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush = 1'b0;
        checkOutput("flushidle_valid", 32'(out_valid), 32'd0);
        checkOutput("flushidle_res", 32'(result_r), 32'(mResult));
        checkOutput("flushidle_ccr", 32'(conditionCodeRegister_r), 32'(mCcr));

        // Back-to-back single-cycle operations
        @(negedge clk);
        Op1 = 16'd1; Op2 = 16'd2; ALUmode = 3'd0; carrySelect = 2'b10;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        modelOp(3'd0, 16'd1, 16'd2, 2'b10);
        checkOutput("b2b1_valid", 32'(out_valid), 32'd1);
        checkOutput("b2b1_res", 32'(result_r), 32'(mResult));
        Op1 = 16'd10; Op2 = 16'd3; ALUmode = 3'd1; carrySelect = 2'b10;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        modelOp(3'd1, 16'd10, 16'd3, 2'b10);
        checkOutput("b2b2_valid", 32'(out_valid), 32'd1);
        checkOutput("b2b2_res", 32'(result_r), 32'd7);
        checkOutput("b2b2_ccr", 32'(conditionCodeRegister_r), 32'(mCcr));

        // NOT / PASS / NOP carry control
        applyStimulus("not", 3'd4, 16'd42, 16'd0, 2'b01);
        checkOutput("not_const", {13'd0, conditionCodeRegister_r, result_r}, {13'd0, 3'b110, 16'hFFD5});
        applyStimulus("pass", 3'd5, 16'd0, 16'd6, 2'b00);
        checkOutput("pass_const", {13'd0, conditionCodeRegister_r, result_r}, {13'd0, 3'b110, 16'd6});
        applyStimulus("nop", 3'd7, 16'hAAAA, 16'h5555, 2'b11);
        checkOutput("nop_const", {13'd0, conditionCodeRegister_r, result_r}, {13'd0, 3'b010, 16'd6});

        // Reset asserted in the middle of a MUL
        @(negedge clk);
        Op1 = 16'hABCD; Op2 = 16'h1234; ALUmode = 3'd6; carrySelect = 2'b01;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        mResult = '0;
        mCcr = '0;
        checkOutput("midrst_res", 32'(result_r), 32'd0);
        checkOutput("midrst_ccr", 32'(conditionCodeRegister_r), 32'd0);
        checkOutput("midrst_valid", 32'(out_valid), 32'd0);
        checkOutput("midrst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        sawValid = 1'b0;
        repeat (MUL_CYCLES + 2) begin
            @(posedge clk);
            #1;
            if (out_valid) sawValid = 1'b1;
        end
        checkOutput("midrst_noretire", 32'(sawValid), 32'd0);
        applyStimulus("mul34", 3'd6, 16'd3, 16'd4, 2'b10);
        checkOutput("mul34_const", 32'(result_r), 32'd12);

        // Randomized operations against the model
        for (int i = 0; i < 150; i++) begin
            applyStimulus("rand", 3'($urandom_range(0, 7)), 16'($urandom),
                          16'($urandom), 2'($urandom_range(0, 3)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
